// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared widths, FSM encodings and grant helper for the SDRAM port arbiter
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_DATA_W = 16;
  localparam int DEBT_W       = 4;
  localparam int DEBT_MAX     = 8;

  typedef logic [DEBT_W-1:0] debt_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE    = 2'd0,
    GNT_PORT0   = 2'd1,
    GNT_PORT1   = 2'd2,
    GNT_REFRESH = 2'd3
  } grant_t;

  // On a tie the port that did not win last time is chosen.
  function automatic grant_t rr_pick(input logic v0, input logic v1, input logic last_grant);
    grant_t g;
    g = GNT_NONE;
    if (v0 && v1) begin
      g = last_grant ? GNT_PORT0 : GNT_PORT1;
    end else if (v0) begin
      g = GNT_PORT0;
    end else if (v1) begin
      g = GNT_PORT1;
    end
    return g;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - port request, read response and controller command bus
interface sdram_port_arbiter_if
  import sdram_pkg::*;
#(
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int DATA_W = SDRAM_DATA_W
);

  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_rdata;

  logic              cmd_valid;
  logic              cmd_refresh;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_ready;
  logic              cmd_done;
  logic [DATA_W-1:0] cmd_rdata;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_rdata,
    output cmd_valid, cmd_refresh, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, cmd_done, cmd_rdata
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_rdata,
    input  cmd_valid, cmd_refresh, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, cmd_done, cmd_rdata
  );

endinterface

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - refresh interval timer, outstanding refresh debt and sticky overrun
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 1250
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_ctrl_ready,
  input  logic  i_refresh_accept,
  output debt_t o_debt,
  output logic  o_overrun
);

  localparam int TMR_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(REFRESH_INTERVAL - 1);

  logic [TMR_W-1:0] r_timer;
  debt_t            r_debt;
  logic             r_overrun;
  logic             w_tick;

  assign w_tick    = (r_timer == '0);
  assign o_debt    = r_debt;
  assign o_overrun = r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer   <= RELOAD;
      r_debt    <= '0;
      r_overrun <= 1'b0;
    end else if (!i_ctrl_ready) begin
      r_timer <= RELOAD;
      r_debt  <= '0;
    end else begin
      r_timer <= w_tick ? RELOAD : r_timer - 1'b1;
      // A tick and an accepted refresh cancel each other out.
      if (w_tick && !i_refresh_accept) begin
        if (r_debt == DEBT_W'(DEBT_MAX)) begin
          r_overrun <= 1'b1;
        end else begin
          r_debt <= r_debt + 1'b1;
        end
      end else if (!w_tick && i_refresh_accept && (r_debt != '0)) begin
        r_debt <= r_debt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port round-robin SDRAM arbiter with refresh scheduling,
// one transaction outstanding at a time.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 1250,
  parameter int REFRESH_URGENT   = 4,
  parameter int ADDR_W           = SDRAM_ADDR_W,
  parameter int DATA_W           = SDRAM_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_ready,
  output logic                 refresh_overrun,
  sdram_port_arbiter_if.master bus
);

  arb_state_t        r_state;
  logic              r_last_grant;
  logic              r_cur_port;
  logic              r_req0_ready;
  logic              r_req1_ready;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_cmd_valid;
  logic              r_cmd_refresh;
  logic              r_cmd_write;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;

  debt_t  w_debt;
  logic   w_overrun;
  logic   w_urgent;
  logic   w_ref_accept;
  logic   w_sel;
  grant_t w_grant;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .clk              (clk),
    .rst              (rst),
    .i_ctrl_ready     (ctrl_ready),
    .i_refresh_accept (w_ref_accept),
    .o_debt           (w_debt),
    .o_overrun        (w_overrun)
  );

  assign w_urgent     = (int'(w_debt) >= REFRESH_URGENT);
  assign w_ref_accept = (r_state == ST_ISSUE) && r_cmd_valid && r_cmd_refresh && bus.cmd_ready;

  // Urgent refresh beats ports; pending refresh only fills idle slots.
  always_comb begin
    w_grant = GNT_NONE;
    if (ctrl_ready) begin
      if (w_urgent) begin
        w_grant = GNT_REFRESH;
      end else if (bus.req0_valid || bus.req1_valid) begin
        w_grant = rr_pick(bus.req0_valid, bus.req1_valid, r_last_grant);
      end else if (w_debt != '0) begin
        w_grant = GNT_REFRESH;
      end
    end
  end

  assign w_sel = (w_grant == GNT_PORT1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= 1'b1;
      r_cur_port    <= 1'b0;
      r_req0_ready  <= 1'b0;
      r_req1_ready  <= 1'b0;
      r_rsp0_valid  <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp_rdata   <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_refresh <= 1'b0;
      r_cmd_write   <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_wdata   <= '0;
    end else begin
      r_req0_ready <= 1'b0;
      r_req1_ready <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant == GNT_REFRESH) begin
            r_cmd_valid   <= 1'b1;
            r_cmd_refresh <= 1'b1;
            r_cmd_write   <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_wdata   <= '0;
            r_state       <= ST_ISSUE;
          end else if (w_grant != GNT_NONE) begin
            r_cmd_valid   <= 1'b1;
            r_cmd_refresh <= 1'b0;
            r_cmd_write   <= w_sel ? bus.req1_write : bus.req0_write;
            r_cmd_addr    <= w_sel ? bus.req1_addr  : bus.req0_addr;
            r_cmd_wdata   <= w_sel ? bus.req1_wdata : bus.req0_wdata;
            r_req0_ready  <= !w_sel;
            r_req1_ready  <= w_sel;
            r_last_grant  <= w_sel;
            r_cur_port    <= w_sel;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.cmd_done) begin
            r_state <= ST_IDLE;
            if (!r_cmd_refresh && !r_cmd_write) begin
              r_rsp0_valid <= !r_cur_port;
              r_rsp1_valid <= r_cur_port;
              r_rsp_rdata  <= bus.cmd_rdata;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = r_req0_ready;
  assign bus.req1_ready  = r_req1_ready;
  assign bus.rsp0_valid  = r_rsp0_valid;
  assign bus.rsp1_valid  = r_rsp1_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.cmd_refresh = r_cmd_refresh;
  assign bus.cmd_write   = r_cmd_write;
  assign bus.cmd_addr    = r_cmd_addr;
  assign bus.cmd_wdata   = r_cmd_wdata;
  assign refresh_overrun = w_overrun;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  localparam int RI  = 16;
  localparam int URG = 4;
  localparam int AW  = 24;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl_ready = 1'b0;
  logic refresh_overrun;

  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_port_arbiter #(
    .REFRESH_INTERVAL (RI),
    .REFRESH_URGENT   (URG),
    .ADDR_W           (AW),
    .DATA_W           (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ctrl_ready      (ctrl_ready),
    .refresh_overrun (refresh_overrun),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: cmd_done two cycles after acceptance unless held off.
  logic [DW-1:0] ctl_rdata = '0;
  logic          ctl_hold = 1'b0;
  int            spur_cnt = 0;
  int            port_done_cyc = 0;

  initial begin : ctl_model
    int   pending;
    int   spur_seen;
    logic cur_ref;
    pending = 0;
    spur_seen = 0;
    cur_ref = 1'b0;
    bus.cmd_done = 1'b0;
    bus.cmd_rdata = '0;
    forever begin
      @(negedge clk);
      bus.cmd_done = 1'b0;
      if (rst) begin
        pending = 0;
      end else begin
        if (spur_seen != spur_cnt) begin
          spur_seen++;
          bus.cmd_done = 1'b1;
        end else if (pending > 0) begin
          pending--;
          if (pending == 0 && !ctl_hold) begin
            bus.cmd_done = 1'b1;
            bus.cmd_rdata = ctl_rdata;
            if (!cur_ref) port_done_cyc = cyc;
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          pending = 2;
          cur_ref = bus.cmd_refresh;
        end
      end
    end
  end

  // Monitor: logs grants, refresh acceptances, port commands and responses.
  int            gnt_n = 0;
  int            gnt_log [256];
  int            ref_n = 0;
  int            ref_cyc [256];
  int            ref_debt [256];
  int            rsp0_n = 0;
  int            rsp1_n = 0;
  int            rsp_cyc = 0;
  logic [DW-1:0] rsp_data = '0;
  logic          mon_w = 1'b0;
  logic [AW-1:0] mon_a = '0;
  logic [DW-1:0] mon_d = '0;
  int            viol_n = 0;
  int            prev_debt = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        if (gnt_n < 256) gnt_log[gnt_n] = bus.req1_ready ? 1 : 0;
        gnt_n++;
        if (prev_debt >= URG) viol_n++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (bus.cmd_refresh) begin
          if (ref_n < 256) begin
            ref_cyc[ref_n] = cyc;
            ref_debt[ref_n] = int'(dut.u_timer.o_debt);
          end
          ref_n++;
        end else begin
          mon_w = bus.cmd_write;
          mon_a = bus.cmd_addr;
          mon_d = bus.cmd_wdata;
        end
      end
      if (bus.rsp0_valid) begin
        rsp0_n++;
        rsp_data = bus.rsp_rdata;
        rsp_cyc = cyc;
      end
      if (bus.rsp1_valid) begin
        rsp1_n++;
        rsp_data = bus.rsp_rdata;
        rsp_cyc = cyc;
      end
      prev_debt = int'(dut.u_timer.o_debt);
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input int port, input logic v, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = wd;
    end else begin
      bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = wd;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ctrl_ready = 1'b0;
    bus.cmd_ready = 1'b1;
    ctl_hold = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  task automatic wait_ready(input int port, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if ((port == 0) ? bus.req0_ready : bus.req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int            port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    int            exp_rsp0;
    int            exp_rsp1;
    logic [DW-1:0] exp_rsp_data;
  } vec_t;

  vec_t vecs [5];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin : main
    int            g0, r0, r1, s0, v0, maxd, mism;
    logic          ok, have;
    logic          cap_ref, cap_w;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;

    vecs[0] = '{1, 1'b0, 24'h012345, 16'h0000, 16'hBEEF, 1'b0, 24'h012345, 16'h0000, 0, 1, 16'hBEEF};
    vecs[1] = '{0, 1'b1, 24'hFFFFFF, 16'hA5A5, 16'h0000, 1'b1, 24'hFFFFFF, 16'hA5A5, 0, 0, 16'h0000};
    vecs[2] = '{0, 1'b0, 24'h000000, 16'h0000, 16'h1234, 1'b0, 24'h000000, 16'h0000, 1, 0, 16'h1234};
    vecs[3] = '{1, 1'b1, 24'h800001, 16'h0001, 16'h0000, 1'b1, 24'h800001, 16'h0001, 0, 0, 16'h0000};
    vecs[4] = '{1, 1'b0, 24'h7FFE00, 16'h0000, 16'hFFFF, 1'b0, 24'h7FFE00, 16'h0000, 0, 1, 16'hFFFF};

    // Reset state, then ctrl_ready low blocks grants and holds debt at zero.
    apply_reset();
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_req_ready", {bus.req0_ready, bus.req1_ready}, 0);
    check("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_overrun", refresh_overrun, 0);
    check("rst_debt", dut.u_timer.o_debt, 0);
    g0 = gnt_n;
    drive(0, 1'b1, 1'b0, 24'h000010, '0);
    step(40);
    check("nordy_grants", gnt_n - g0, 0);
    check("nordy_debt", dut.u_timer.o_debt, 0);
    check("nordy_cmd_valid", bus.cmd_valid, 0);
    drive(0, 1'b0, 1'b0, '0, '0);
    step(1);

    // Single-port transactions from the vector table.
    ctrl_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      g0 = gnt_n; r0 = rsp0_n; r1 = rsp1_n;
      ctl_rdata = vecs[i].rdata;
      drive(vecs[i].port, 1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_ready(vecs[i].port, ok);
      drive(vecs[i].port, 1'b0, 1'b0, '0, '0);
      check($sformatf("v%0d_ready", i), ok, 1);
      step(8);
      check($sformatf("v%0d_grants", i), gnt_n - g0, 1);
      check($sformatf("v%0d_port", i), gnt_log[g0], vecs[i].port);
      check($sformatf("v%0d_cmd_write", i), mon_w, vecs[i].exp_wr);
      check($sformatf("v%0d_cmd_addr", i), mon_a, vecs[i].exp_addr);
      check($sformatf("v%0d_cmd_wdata", i), mon_d, vecs[i].exp_wdata);
      check($sformatf("v%0d_rsp0_pulses", i), rsp0_n - r0, vecs[i].exp_rsp0);
      check($sformatf("v%0d_rsp1_pulses", i), rsp1_n - r1, vecs[i].exp_rsp1);
      if (!vecs[i].wr) begin
        check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_rsp_data);
        check($sformatf("v%0d_rsp_latency", i), rsp_cyc - port_done_cyc, 1);
      end
    end

    // Both ports valid continuously: first grant port 0, then alternate.
    apply_reset();
    ctrl_ready = 1'b1;
    g0 = gnt_n;
    drive(0, 1'b1, 1'b0, 24'h000100, '0);
    drive(1, 1'b1, 1'b0, 24'h000200, '0);
    for (int i = 0; i < 60 && (gnt_n - g0) < 4; i++) step(1);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    check("rr_count", ((gnt_n - g0) >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4; k++) check($sformatf("rr_grant%0d", k), gnt_log[g0 + k], k % 2);
    step(8);

    // No requests: refresh every RI cycles, debt never above 1.
    apply_reset();
    ctrl_ready = 1'b1;
    s0 = ref_n;
    maxd = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (int'(dut.u_timer.o_debt) > maxd) maxd = int'(dut.u_timer.o_debt);
    end
    check("ref_count", ((ref_n - s0) >= 5) ? 1 : 0, 1);
    for (int k = 1; k < 5; k++)
      check($sformatf("ref_period%0d", k), ref_cyc[s0 + k] - ref_cyc[s0 + k - 1], RI);
    check("ref_max_debt", maxd, 1);

    // Continuous traffic: refresh preempts only once debt reaches URG.
    apply_reset();
    ctrl_ready = 1'b1;
    s0 = ref_n; g0 = gnt_n; v0 = viol_n;
    drive(0, 1'b1, 1'b1, 24'h000300, 16'h0303);
    drive(1, 1'b1, 1'b1, 24'h000400, 16'h0404);
    for (int i = 0; i < 200 && ref_n == s0; i++) step(1);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    check("urg_ref_seen", (ref_n > s0) ? 1 : 0, 1);
    check("urg_debt_at_ref", ref_debt[s0], URG);
    check("urg_port_grants_ok", ((gnt_n - g0) >= 8) ? 1 : 0, 1);
    check("urg_no_grant_over_debt", viol_n - v0, 0);
    step(10);

    // cmd_ready stuck low: debt saturates at 8, ninth tick sets overrun.
    apply_reset();
    bus.cmd_ready = 1'b0;
    ctrl_ready = 1'b1;
    have = 1'b0; mism = 0;
    cap_ref = 1'b0; cap_w = 1'b0; cap_a = '0; cap_d = '0;
    for (int i = 0; i < 9 * RI + 4; i++) begin
      step(1);
      if (bus.cmd_valid && !have) begin
        have = 1'b1;
        cap_ref = bus.cmd_refresh; cap_w = bus.cmd_write; cap_a = bus.cmd_addr; cap_d = bus.cmd_wdata;
      end else if (have) begin
        if (!bus.cmd_valid || bus.cmd_refresh !== cap_ref || bus.cmd_write !== cap_w ||
            bus.cmd_addr !== cap_a || bus.cmd_wdata !== cap_d) mism++;
      end
      if (i == 8 * RI + 3) begin
        check("ovr_debt_at_8_ticks", dut.u_timer.o_debt, 8);
        check("ovr_flag_at_8_ticks", refresh_overrun, 0);
      end
    end
    check("ovr_cmd_seen", have, 1);
    check("ovr_cmd_refresh", cap_ref, 1);
    check("ovr_fields_stable", mism, 0);
    check("ovr_debt", dut.u_timer.o_debt, 8);
    check("ovr_flag", refresh_overrun, 1);
    bus.cmd_ready = 1'b1;
    step(10);
    check("ovr_sticky", refresh_overrun, 1);
    apply_reset();
    check("ovr_cleared_by_rst", refresh_overrun, 0);

    // Reset in WAIT_DONE of a port-0 read.
    ctrl_ready = 1'b1;
    ctl_rdata = 16'hC0DE;
    drive(0, 1'b1, 1'b0, 24'h00ABCD, '0);
    wait_ready(0, ok);
    drive(0, 1'b0, 1'b0, '0, '0);
    step(8);
    check("mid_pre_rdata", bus.rsp_rdata, 16'hC0DE);
    ctl_hold = 1'b1;
    drive(0, 1'b1, 1'b0, 24'h00ABCD, '0);
    wait_ready(0, ok);
    drive(0, 1'b0, 1'b0, '0, '0);
    check("mid_ready", ok, 1);
    step(4);
    check("mid_in_wait_done", int'(dut.r_state), 2);
    r0 = rsp0_n; r1 = rsp1_n; g0 = gnt_n;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_valid", bus.cmd_valid, 0);
    check("mid_rst_cmd_addr", bus.cmd_addr, 0);
    check("mid_rst_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    check("mid_rst_rdata", bus.rsp_rdata, 0);
    check("mid_rst_state", int'(dut.r_state), 0);
    step(2);
    ctrl_ready = 1'b0;
    rst = 1'b0;
    ctl_hold = 1'b0;
    step(10);
    spur_cnt++;
    step(4);
    check("mid_no_rsp", (rsp0_n - r0) + (rsp1_n - r1), 0);
    check("mid_spurious_done_ignored", int'(dut.r_state), 0);
    ctrl_ready = 1'b1;
    drive(0, 1'b1, 1'b0, 24'h000500, '0);
    drive(1, 1'b1, 1'b0, 24'h000600, '0);
    for (int i = 0; i < 40 && gnt_n == g0; i++) step(1);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    step(2);
    check("mid_next_grant_seen", (gnt_n > g0) ? 1 : 0, 1);
    check("mid_next_grant_port0", gnt_log[g0], 0);
    step(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 1250: clk cycles between refresh ticks (7.8 us at 160 MHz).
REQ-002 Parameter REFRESH_URGENT, default 4: refresh debt at which refresh preempts new grants.
REQ-003 Parameter ADDR_W, default 24: {bank[1:0], row[12:0], col[8:0]}.
REQ-004 Parameter DATA_W, default 16: data bus width.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 ctrl_ready  in  1  SDRAM controller has finished its init sequence.
REQ-009 reqN_valid  in  1  port N (N=0,1) request; held stable until reqN_ready.
REQ-010 reqN_write  in  1  1 = write, 0 = read.
REQ-011 reqN_addr  in  ADDR_W  request address.
REQ-012 reqN_wdata  in  DATA_W  write data.
REQ-013 reqN_ready  out  1  one-cycle pulse; request accepted.
REQ-014 rspN_valid  out  1  one-cycle pulse; read data for port N on rsp_rdata.
REQ-015 rsp_rdata  out  DATA_W  registered read data.
REQ-016 cmd_valid  out  1  command to controller.
REQ-017 cmd_refresh  out  1  command is auto-refresh; addr/write ignored.
REQ-018 cmd_write, cmd_addr, cmd_wdata  out  1/ADDR_W/DATA_W  command fields.
REQ-019 cmd_ready  in  1  controller accepts the command this cycle.
REQ-020 cmd_done  in  1  command complete; read data valid on cmd_rdata.
REQ-021 cmd_rdata  in  DATA_W  read data from controller.
REQ-022 refresh_overrun  out  1  sticky: refresh debt saturated.

Function
REQ-023 The FSM SHALL use states IDLE, ISSUE, WAIT_DONE; one transaction outstanding at a time.
REQ-024 In IDLE with ctrl_ready=1, arbitration SHALL choose, in priority order: refresh if debt >= REFRESH_URGENT; a valid port (round-robin); refresh if debt > 0; else stay IDLE.
REQ-025 Round-robin: if both ports are valid, grant the port != last_grant; a single valid port is always granted; last_grant updates on every port grant.
REQ-026 A grant decided in cycle t SHALL assert cmd_valid with registered fields and reqN_ready (single pulse) in cycle t+1, state ISSUE.
REQ-027 ISSUE SHALL hold cmd_valid and all fields stable until cmd_ready=1, then go to WAIT_DONE with cmd_valid=0 on the next cycle.
REQ-028 WAIT_DONE SHALL go to IDLE on cmd_done; for a port read, rspN_valid=1 and rsp_rdata=cmd_rdata SHALL appear one cycle after cmd_done.
REQ-029 Refresh commands SHALL produce no rsp pulse; debt SHALL decrement when the refresh is accepted (cmd_valid & cmd_ready).
REQ-030 The refresh timer SHALL count down from REFRESH_INTERVAL-1 and tick at 0, then reload; each tick SHALL increment debt.
REQ-031 A tick and a refresh acceptance in the same cycle SHALL leave debt unchanged.
REQ-032 Debt SHALL saturate at 8; a tick at debt=8 SHALL set refresh_overrun until reset.
REQ-033 While ctrl_ready=0: no grants, timer held at reload, debt held at 0.
REQ-034 cmd_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-035 rst SHALL force IDLE, all outputs 0, debt 0, timer at reload, overrun 0, last_grant=1 (port 0 wins first tie), including mid-transaction.

Structure
REQ-036 Package sdram_pkg SHALL hold ADDR_W/DATA_W defaults, FSM state encodings and debt width.
REQ-037 Sub-module sdram_refresh_timer SHALL implement the timer, debt counter and overrun flag.

Verification
REQ-038 Both ports valid at once, repeated: grants alternate 0,1,0,1; first grant goes to port 0.
REQ-039 Port 1 read at addr 0x012345, controller returns 0xBEEF: cmd_addr=0x012345, rsp1_valid one pulse with 0xBEEF, rsp0_valid stays 0.
REQ-040 REFRESH_INTERVAL=16, no requests: cmd_refresh issued every 16 cycles; debt never exceeds 1.
REQ-041 Continuous port traffic, REFRESH_URGENT=4: after 4 ticks the next IDLE issues refresh before any port grant.
REQ-042 cmd_ready tied low for 9 x REFRESH_INTERVAL: refresh_overrun=1, debt=8; cmd fields stable throughout.
REQ-043 rst pulsed during WAIT_DONE of a read: outputs 0 immediately, no rsp pulse, next grant goes to port 0.
